// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus a shift-add multiplier.
// RESULT and flags commit together on the registered DONE pulse.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             FLAG_C,
    output logic             FLAG_Z,
    output logic             FLAG_B
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, FIN} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_val;
    logic                 r_c;
    logic                 r_bw;
    logic                 r_wr_res;
    logic                 r_wr_flg;
    logic [WIDTH-1:0]     r_result;
    logic                 r_fc;
    logic                 r_fz;
    logic                 r_fb;
    logic                 r_done;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_inc;
    logic [WIDTH-1:0]     w_val;
    logic                 w_c;
    logic                 w_bw;
    logic                 w_wr_res;
    logic                 w_wr_flg;
    logic                 w_mul_end;

    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    assign w_inc     = {1'b0, r_a} + {{WIDTH{1'b0}}, 1'b1};
    assign w_mul_end = (r_cnt == CW'(WIDTH));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (START) w_next = (OP == OP_MUL) ? MUL : EXEC;
            EXEC: w_next = FIN;
            MUL:  if (w_mul_end) w_next = FIN;
            FIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Single-cycle datapath; write enables make CMP flags-only and C-F a NOP.
    always_comb begin
        w_val    = '0;
        w_c      = 1'b0;
        w_bw     = 1'b0;
        w_wr_res = 1'b1;
        w_wr_flg = 1'b1;
        case (r_op)
            OP_ADD: {w_c, w_val} = w_sum;
            OP_SUB: begin w_val = r_a - r_b; w_bw = (r_a < r_b); end
            OP_AND: w_val = r_a & r_b;
            OP_OR:  w_val = r_a | r_b;
            OP_XOR: w_val = r_a ^ r_b;
            OP_NOT: w_val = ~r_a;
            OP_SHL: begin w_val = r_a << 1; w_c = r_a[WIDTH-1]; end
            OP_SHR: begin w_val = r_a >> 1; w_c = r_a[0]; end
            OP_INC: {w_c, w_val} = w_inc;
            OP_DEC: begin w_val = r_a - 1'b1; w_bw = (r_a == '0); end
            OP_CMP: begin
                w_val    = r_a - r_b;
                w_bw     = (r_a < r_b);
                w_wr_res = 1'b0;
            end
            default: begin
                w_wr_res = 1'b0;
                w_wr_flg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_val    <= '0;
            r_c      <= 1'b0;
            r_bw     <= 1'b0;
            r_wr_res <= 1'b0;
            r_wr_flg <= 1'b0;
            r_result <= '0;
            r_fc     <= 1'b0;
            r_fz     <= 1'b0;
            r_fb     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: if (START) begin
                    r_op    <= OP;
                    r_a     <= A;
                    r_b     <= B;
                    r_mcand <= {{WIDTH{1'b0}}, A};
                    r_prod  <= '0;
                    r_cnt   <= '0;
                end
                EXEC: begin
                    r_val    <= w_val;
                    r_c      <= w_c;
                    r_bw     <= w_bw;
                    r_wr_res <= w_wr_res;
                    r_wr_flg <= w_wr_flg;
                end
                // One multiplier bit per cycle, then one cycle to stage the product.
                MUL: if (!w_mul_end) begin
                    if (r_b[0]) r_prod <= r_prod + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                end else begin
                    r_val    <= r_prod[WIDTH-1:0];
                    r_c      <= |r_prod[2*WIDTH-1:WIDTH];
                    r_bw     <= 1'b0;
                    r_wr_res <= 1'b1;
                    r_wr_flg <= 1'b1;
                end
                FIN: begin
                    r_done <= 1'b1;
                    if (r_wr_res) r_result <= r_val;
                    if (r_wr_flg) begin
                        r_fc <= r_c;
                        r_fz <= (r_val == '0);
                        r_fb <= r_bw;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RESULT = r_result;
    assign BUSY   = (r_state != IDLE);
    assign DONE   = r_done;
    assign FLAG_C = r_fc;
    assign FLAG_Z = r_fz;
    assign FLAG_B = r_fb;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops queue expected results,
// a negedge monitor checks values, latency and BUSY length on DONE.
module tb_alu_seq;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [3:0] OP = 4'h0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [7:0] RESULT;
    logic       BUSY, DONE, FLAG_C, FLAG_Z, FLAG_B;

    alu_seq #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE),
        .FLAG_C(FLAG_C), .FLAG_Z(FLAG_Z), .FLAG_B(FLAG_B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] res;
        logic       c, z, b;
        int         due;
        int         lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DONE=1 want no DONE (cyc %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("result", int'(RESULT), int'(e.res));
                check("flag_c", int'(FLAG_C), int'(e.c));
                check("flag_z", int'(FLAG_Z), int'(e.z));
                check("flag_b", int'(FLAG_B), int'(e.b));
                check("latency", cyc, e.due);
                check("busy_len", busy_cnt, e.lat);
            end
        end
        if (BUSY) busy_cnt++;
        else busy_cnt = 0;
    end

    task automatic pulse(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res,
                         input logic c, input logic z, input logic bw);
        exp_t x;
        int   lat;
        lat = (op == 4'hB) ? 10 : 2;
        @(negedge CLK);
        x.res = res; x.c = c; x.z = z; x.b = bw;
        x.due = cyc + 1 + lat;
        x.lat = lat;
        q.push_back(x);
        START = 1'b1; OP = op; A = a; B = b;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            @(negedge CLK);
            #1;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res,
                       input logic c, input logic z, input logic bw);
        issue(op, a, b, res, c, z, bw);
        wait_done();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, int'(BUSY), 0);
        check({tag, "_done"}, int'(DONE), 0);
        check({tag, "_result"}, int'(RESULT), 0);
        check({tag, "_flags"}, int'({FLAG_C, FLAG_Z, FLAG_B}), 0);
    endtask

    initial begin
        // START held during reset must be discarded
        RST = 1'b1; START = 1'b1; OP = 4'h0; A = 8'h11; B = 8'h22;
        repeat (3) @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        #1;
        check_reset_state("reset");
        @(negedge CLK);
        #1;
        check("post_reset_busy", int'(BUSY), 0);

        run(4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
        run(4'h1, 8'h03, 8'h05, 8'hFE, 0, 0, 1);
        run(4'hA, 8'h07, 8'h07, 8'hFE, 0, 1, 0);
        run(4'hB, 8'h10, 8'h10, 8'h00, 1, 1, 0);
        run(4'hB, 8'h0C, 8'h0A, 8'h78, 0, 0, 0);

        // START during MUL is ignored
        issue(4'hB, 8'h03, 8'h05, 8'h0F, 0, 0, 0);
        repeat (2) @(negedge CLK);
        pulse(4'h0, 8'h01, 8'h01);
        wait_done();
        repeat (3) @(negedge CLK);

        // Reset in the middle of a MUL
        pulse(4'hB, 8'h0F, 8'h0F);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_reset_state("mid_mul_reset");
        run(4'h6, 8'h81, 8'h00, 8'h02, 1, 0, 0);

        // Undefined opcode is a NOP
        run(4'h0, 8'hF0, 8'h20, 8'h10, 1, 0, 0);
        run(4'hE, 8'h05, 8'h09, 8'h10, 1, 0, 0);

        run(4'h2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0);
        run(4'h3, 8'h0F, 8'h30, 8'h3F, 0, 0, 0);
        run(4'h4, 8'hAA, 8'hAA, 8'h00, 0, 1, 0);
        run(4'h5, 8'h0F, 8'h00, 8'hF0, 0, 0, 0);
        run(4'h7, 8'h01, 8'h00, 8'h00, 1, 1, 0);
        run(4'h8, 8'hFF, 8'h00, 8'h00, 1, 1, 0);
        run(4'h9, 8'h00, 8'h00, 8'hFF, 0, 0, 1);
        run(4'hA, 8'h02, 8'h09, 8'hFF, 0, 0, 1);
        run(4'hB, 8'hFF, 8'hFF, 8'h01, 1, 0, 0);

        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
